// File: rtl/mips_mem_pkg.sv
// -----------------------------------------------------------------------------
// mips_mem_pkg
// Shared types and constants for the data-memory arbiter slice.
//   state_t  : arbiter FSM states (IDLE / ACCESS / RESP)
//   req_id_t : identifies which of the two requesters owns a transaction
//   DEF_AW / DEF_DW : default address and data widths
//   CNT_W    : width of the memory-latency down-counter
// -----------------------------------------------------------------------------
package mips_mem_pkg;

   localparam int DEF_AW = 32;
   localparam int DEF_DW = 32;
   localparam int CNT_W  = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   typedef logic req_id_t;

   localparam req_id_t REQ0 = 1'b0;
   localparam req_id_t REQ1 = 1'b1;

endpackage

// File: rtl/rr_arbiter_2.sv
// -----------------------------------------------------------------------------
// rr_arbiter_2
// Two-way round-robin arbiter, purely combinational.
//   i_valid0 / i_valid1 : requester 0 / 1 wants the memory
//   i_lastGrant         : requester granted by the most recent transfer
//   o_grant             : one-hot grant (bit n = requester n), 0 if nobody asks
// -----------------------------------------------------------------------------
module rr_arbiter_2
   import mips_mem_pkg::*;
(
   input  logic       i_valid0,
   input  logic       i_valid1,
   input  req_id_t    i_lastGrant,
   output logic [1:0] o_grant
);

   // A lone requester always wins. When both ask, the one that was not
   // granted last time goes first, so neither side can be starved.
   always_comb begin
      o_grant = 2'b00;
      if (i_valid0 && (!i_valid1 || (i_lastGrant == REQ1))) begin
         o_grant[0] = 1'b1;
      end else if (i_valid1) begin
         o_grant[1] = 1'b1;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares one data-memory port between two requesters using round-robin
// arbitration. Each accepted transaction holds the memory strobes for MEM_LAT
// cycles and then returns a one-cycle completion pulse to its owner.
//   clk, rst                 : clock, asynchronous active-low reset
//   reqN_valid/_ready        : request handshake for requester N
//   reqN_we/_addr/_wdata     : request contents (we=1 write, we=0 read)
//   rspN_valid/_rdata        : completion pulse and read data for requester N
//   mem_addr/_wdata          : shared memory address / write data
//   mem_read/_write          : shared memory strobes
//   mem_rdata                : combinational read data from memory
//   busy                     : high whenever a transaction is in flight
// -----------------------------------------------------------------------------
module dmem_arbiter
   import mips_mem_pkg::*;
#(
   parameter int MEM_LAT = 1,
   parameter int AW      = DEF_AW,
   parameter int DW      = DEF_DW
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          req0_valid,
   output logic          req0_ready,
   input  logic          req0_we,
   input  logic [AW-1:0] req0_addr,
   input  logic [DW-1:0] req0_wdata,
   input  logic          req1_valid,
   output logic          req1_ready,
   input  logic          req1_we,
   input  logic [AW-1:0] req1_addr,
   input  logic [DW-1:0] req1_wdata,
   output logic          rsp0_valid,
   output logic [DW-1:0] rsp0_rdata,
   output logic          rsp1_valid,
   output logic [DW-1:0] rsp1_rdata,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic          mem_read,
   output logic          mem_write,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy
);

   // The latency counter is only CNT_W bits wide, so refuse to build with a
   // latency it cannot represent.
   generate
      if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_latCheck
         $error("dmem_arbiter: MEM_LAT must be within 1..15");
      end
   endgenerate

   localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT - 1);

   state_t           r_state;
   state_t           w_nextState;
   logic [CNT_W-1:0] r_cnt;
   req_id_t          r_lastGrant;
   req_id_t          r_id;
   logic             r_we;
   logic [AW-1:0]    r_addr;
   logic [DW-1:0]    r_wdata;
   logic [DW-1:0]    r_rdata0;
   logic [DW-1:0]    r_rdata1;
   logic [1:0]       w_grant;
   logic             w_xfer;
   logic             w_accessDone;

   rr_arbiter_2 u_arb (
      .i_valid0    (req0_valid),
      .i_valid1    (req1_valid),
      .i_lastGrant (r_lastGrant),
      .o_grant     (w_grant)
   );

   // The arbiter only grants a requester that is valid, so any grant while
   // idle is a completed handshake.
   assign w_xfer       = (r_state == IDLE) && (w_grant != 2'b00);
   assign w_accessDone = (r_state == ACCESS) && (r_cnt == '0);

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic: wait for a handshake, hold the strobes until the
   // counter runs out, then spend exactly one cycle answering.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    if (w_xfer) w_nextState = ACCESS;
         ACCESS:  if (w_accessDone) w_nextState = RESP;
         RESP:    w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   // Output logic. Ready is also gated by rst because it is combinational
   // from the requester valids and would otherwise leak through while the
   // state register is being held in reset.
   always_comb begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      rsp0_valid = 1'b0;
      rsp1_valid = 1'b0;
      busy       = (r_state != IDLE);
      case (r_state)
         IDLE: begin
            req0_ready = rst & w_grant[0];
            req1_ready = rst & w_grant[1];
         end
         ACCESS: begin
            mem_addr  = r_addr;
            mem_wdata = r_wdata;
            mem_read  = !r_we;
            mem_write = r_we;
         end
         RESP: begin
            rsp0_valid = (r_id == REQ0);
            rsp1_valid = (r_id == REQ1);
         end
         default: begin
            busy = 1'b1;
         end
      endcase
   end

   assign rsp0_rdata = r_rdata0;
   assign rsp1_rdata = r_rdata1;

   // Datapath: capture the winning request at the handshake so requester
   // inputs can change freely afterwards, count down the strobe cycles, and
   // latch read data on the last strobe cycle into the owner's response
   // register. Each response register keeps its value until that same
   // requester completes another transaction.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt       <= '0;
         r_lastGrant <= REQ1;
         r_id        <= REQ0;
         r_we        <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_rdata0    <= '0;
         r_rdata1    <= '0;
      end else begin
         if (w_xfer) begin
            r_cnt       <= LAT_LOAD;
            r_id        <= w_grant[1] ? REQ1 : REQ0;
            r_lastGrant <= w_grant[1] ? REQ1 : REQ0;
            r_we        <= w_grant[1] ? req1_we    : req0_we;
            r_addr      <= w_grant[1] ? req1_addr  : req0_addr;
            r_wdata     <= w_grant[1] ? req1_wdata : req0_wdata;
         end else if ((r_state == ACCESS) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
         end
         if (w_accessDone) begin
            if (r_id == REQ0) begin
               r_rdata0 <= r_we ? '0 : mem_rdata;
            end else begin
               r_rdata1 <= r_we ? '0 : mem_rdata;
            end
         end
      end
   end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: MEM_LAT, default 1, number of cycles memory strobes are held per access (legal range 1..15).
REQ-002 Parameter: AW, default 32, address width; DW, default 32, data width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 req0_valid / req1_valid  input  1  requester n presents a transaction.
REQ-006 req0_ready / req1_ready  output  1  requester n transaction accepted this cycle.
REQ-007 req0_we / req1_we  input  1  1 = write, 0 = read.
REQ-008 req0_addr / req1_addr  input  AW  byte address.
REQ-009 req0_wdata / req1_wdata  input  DW  write data.
REQ-010 rsp0_valid / rsp1_valid  output  1  one-cycle completion pulse to requester n.
REQ-011 rsp0_rdata / rsp1_rdata  output  DW  read data, valid with rsp_valid.
REQ-012 mem_addr  output  AW;  mem_wdata  output  DW;  mem_read, mem_write  output  1  shared data-memory port.
REQ-013 mem_rdata  input  DW  combinational read data from data memory.
REQ-014 busy  output  1  high whenever state is not IDLE.

Function
REQ-015 FSM states IDLE, ACCESS, RESP; IDLE -> ACCESS on accepted handshake; ACCESS -> RESP after MEM_LAT cycles; RESP -> IDLE unconditionally.
REQ-016 Handshake: reqN_ready asserted combinationally only in IDLE and only for the arbitration winner; transfer occurs when reqN_valid && reqN_ready.
REQ-017 Arbitration: round-robin on last_grant; single valid requester wins; both valid -> requester not last granted wins.
REQ-018 On transfer, addr, wdata, we, granted id captured into registers; requester inputs ignored until next IDLE.
REQ-019 ACCESS: mem_addr/mem_wdata from captured registers; mem_read = !we, mem_write = we, held exactly MEM_LAT cycles via down-counter loaded with MEM_LAT-1.
REQ-020 Final ACCESS cycle of a read registers mem_rdata; writes register 0.
REQ-021 RESP: rspN_valid high one cycle for granted id only; rspN_rdata = registered data; other requester rsp_valid = 0.
REQ-022 Latency: handshake in cycle N -> strobes cycles N+1..N+MEM_LAT -> rsp_valid in cycle N+MEM_LAT+1; next handshake earliest N+MEM_LAT+2.
REQ-023 Outside ACCESS: mem_read = mem_write = 0, mem_addr = 0, mem_wdata = 0.
REQ-024 rspN_rdata holds last value until next RESP for that requester.
REQ-025 last_grant updates only on transfer; idle cycles do not rotate priority.
REQ-026 Requester deasserting valid before ready: no transfer, no priority change.

Reset
REQ-027 rst low asynchronously forces IDLE, counter 0, last_grant = 1 (req0 wins first contention), all captured registers 0.
REQ-028 During reset all outputs 0, including mem strobes and ready; reset mid-ACCESS aborts transaction with no rsp_valid issued.
REQ-029 First handshake possible in first rising edge after rst deasserts.

Structure
REQ-030 Shared package mips_mem_pkg holds state enum (IDLE/ACCESS/RESP), requester-id typedef, default AW/DW constants.
REQ-031 One sub-module rr_arbiter_2: inputs two valids, last_grant; outputs one-hot grant; purely combinational.
REQ-032 Counter width 4 bits; MEM_LAT outside 1..15 is an elaboration error.

Verification
REQ-033 Single read: MEM_LAT=1, req0 read addr 0x10, mem_rdata 0xDEADBEEF -> mem_read one cycle, rsp0_valid next cycle with 0xDEADBEEF.
REQ-034 Contention: both valid from reset -> req0 granted first, req1 granted at N+MEM_LAT+2; repeated contention alternates 0,1,0,1.
REQ-035 Write: MEM_LAT=3, req1 write 0x20 data 0x12345678 -> mem_write high 3 cycles with that addr/data, rsp1_valid with rdata 0.
REQ-036 Reset mid-ACCESS: rst low in second strobe cycle -> strobes drop same cycle, busy 0, no rsp_valid; after release req0 wins contention.
REQ-037 Idle gap: req1 served, 5 idle cycles, then both valid -> req0 wins (priority not rotated by idle).
REQ-038 Valid withdrawn: req1 valid one cycle while busy then dropped -> no transfer, no rsp1_valid, last_grant unchanged.
